multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the shared single-ALU, single-memory multicycle datapath.
- Supports the core ISA: add, and, or, sub, slt, addi, lw, sw, beq.
- Sits between the instruction register and the datapath muxes and enables, replacing the one-shot decoder with per-state control.
- Owns the memory request handshake, traps on illegal encodings or memory timeout, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 255: maximum number of wait cycles for mem_ready before trapping. Must be >= 1.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ins  in  32  instruction register output; stable from DECODE until the next FETCH completes
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completion; sampled only while mem_req=1
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable (valid with mem_req)
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- ir_we  out  1  instruction register load
- pc_we  out  1  PC load
- pc_src  out  2  PC source: 00=ALU result, 01=ALUOut
- alu_src_a  out  1  ALU A select: 0=PC, 1=rs
- alu_src_b  out  2  ALU B select: 00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
- alu_op  out  4  ALU function: and=0000, or=0001, add=0010, sub=0110, slt=0111
- reg_we  out  1  register file write enable
- reg_dst  out  1  write-register select: 0=rt, 1=rd
- mem_to_reg  out  1  write-back data select: 0=ALUOut, 1=memory data
- trap  out  1  sticky; set on trap entry, cleared only by rst
- trap_cause  out  2  01=illegal opcode/funct, 10=memory timeout
- instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W
- state  out  4  current state encoding, for debug

Behaviour:
- Reset:
  - rst=1 at an edge forces state=IDLE, trap=0, trap_cause=00, instr_count=0, wait counter=0.
  - In IDLE all control outputs are 0 and alu_op=0010.
  - IDLE always proceeds to FETCH on the next edge.
  - rst asserted mid-wait drops mem_req at the next edge; the pending access is abandoned.
- Default output values: any control output not listed for a state is 0; alu_op defaults to 0010.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=0010.
  - ir_we and pc_we equal mem_ready (Mealy), so IR and PC load in the same cycle.
  - Transition to DECODE on mem_ready.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, add (precomputes the branch target into ALUOut).
  - Next state by opcode: 000000 with a valid funct -> EXEC_R; 001000 -> EXEC_I; 100011 or 101011 -> ADDR; 000100 -> BRANCH.
  - Any other opcode, or an unknown funct (not 100000, 100100, 100101, 100010, 101010), -> TRAP with cause 01.
- EXEC_R:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op decoded from funct.
  - Next state: WB_R.
- WB_R: reg_we=1, reg_dst=1, mem_to_reg=0; next state FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, add; next state WB_I.
- WB_I: reg_we=1, reg_dst=0, mem_to_reg=0; next state FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, add; next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, iord=1; transition to WB_MEM on mem_ready.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1; next state FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; transition to FETCH on mem_ready.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=0110, pc_src=01, pc_we=zero (Mealy).
  - Next state: FETCH.
- TRAP:
  - All control outputs 0.
  - State, trap and trap_cause hold until rst.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Clears on entry to a wait state and increments each cycle mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready=0 -> TRAP, cause 10.
  - If mem_ready=1 on that same cycle, ready wins and there is no trap.
  - mem_ready is ignored in all other states.
- instr_count increments on each transition into FETCH from WB_R, WB_I, WB_MEM, MEM_WR or BRANCH.
- Latency, with mem_ready=1 on the first request cycle:
  - beq 3 cycles
  - R-type, addi, sw 4 cycles
  - lw 5 cycles
  - Each memory wait cycle adds 1.

Test Plan:
- Reset, then ins=add $3,$1,$2 (0x00221820) with mem_ready tied 1.
  - Expected states: IDLE, FETCH, DECODE, EXEC_R, WB_R, FETCH.
  - alu_op=0010 in EXEC_R; reg_we=1 and reg_dst=1 in WB_R; instr_count=1.
- lw 0x8C220004 with mem_ready delayed 3 cycles in MEM_RD.
  - mem_req and iord held for 4 cycles.
  - WB_MEM asserts mem_to_reg=1 and reg_we=1.
- beq: with zero=1, pc_we=1 and pc_src=01 in BRANCH; with zero=0, pc_we=0.
  - Both cases retire in 3 cycles.
- Illegal opcode 0xFC000000 -> TRAP, trap=1, trap_cause=01.
  - Outputs stay quiet for 10 further cycles; rst returns the block to IDLE.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH: TRAP with cause 10 after the 4th wait cycle.
  - A repeat run with mem_ready=1 exactly on that cycle proceeds to DECODE instead.
- CNT_W=2: retire 5 addi instructions -> instr_count=1 (wrap).
  - Asserting rst during a MEM_WR wait drops mem_req on the next edge.

Source files
------------

// File: rtl/multicycle_control.sv
// Control sequencer for the shared single-ALU, single-memory multicycle datapath.
// Core ISA: add, and, or, sub, slt, addi, lw, sw, beq.
//
// State encoding on the debug 'state' port:
//   0 IDLE   1 FETCH  2 DECODE  3 EXEC_R  4 WB_R    5 EXEC_I  6 WB_I
//   7 ADDR   8 MEM_RD 9 WB_MEM  10 MEM_WR 11 BRANCH 12 TRAP
//
// Memory handshake: mem_req is high for every cycle spent in FETCH, MEM_RD or
// MEM_WR. An access completes at the first rising edge where mem_req=1 and
// mem_ready=1; mem_ready is ignored whenever mem_req=0. An access that has
// not completed after MEM_TIMEOUT consecutive not-ready cycles traps
// (cause 10). MEM_TIMEOUT must be at least 1.
//
// Moore controls are registered from the next state, so they change cleanly
// on the edge that enters a state. ir_we and pc_we carry the Mealy terms
// (mem_ready in FETCH, zero in BRANCH) and are decoded from the current state.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  // Wait counter only ever holds 0 .. MEM_TIMEOUT-1.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_EXEC_I = 4'd5,
    S_WB_I   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_WB_MEM = 4'd9,
    S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Registered Moore controls.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  state_t             cur;
  state_t             nxt;
  logic [1:0]         cause_n;
  ctrl_t              ctrl_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]   count_q;
  logic               trap_q;
  logic [1:0]         cause_q;
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               in_wait;
  logic               timeout_hit;
  logic               retire;
  logic               unused_ins;

  assign opcode     = ins[31:26];
  assign funct      = ins[5:0];
  // Register fields and immediate are routed by the datapath, not used here.
  assign unused_ins = ^ins[25:6];

  function automatic logic funct_valid(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_AND) || (fn == FN_OR) ||
           (fn == FN_SUB) || (fn == FN_SLT);
  endfunction

  function automatic logic [3:0] alu_of_funct(input logic [5:0] fn);
    logic [3:0] op;
    case (fn)
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SUB:  op = ALU_SUB;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Moore control word for a state; fn only matters for EXEC_R.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] fn);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = alu_of_funct(fn);
      end
      S_WB_R: begin
        c.reg_we  = 1'b1;
        c.reg_dst = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_WB_I: begin
        c.reg_we = 1'b1;
      end
      S_MEM_RD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_we     = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_SUB;
        c.pc_src    = 2'b01;
      end
      default: ;
    endcase
    return c;
  endfunction

  assign in_wait     = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
  assign timeout_hit = in_wait && !mem_ready &&
                       (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign retire      = (nxt == S_FETCH) &&
                       ((cur == S_WB_R) || (cur == S_WB_I) || (cur == S_WB_MEM) ||
                        (cur == S_MEM_WR) || (cur == S_BRANCH));

  // Next-state and trap-cause selection.
  always_comb begin
    nxt     = cur;
    cause_n = 2'b00;
    case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          nxt = S_DECODE;
        end else if (timeout_hit) begin
          nxt     = S_TRAP;
          cause_n = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (opcode == OP_RTYPE && funct_valid(funct)) begin
          nxt = S_EXEC_R;
        end else if (opcode == OP_ADDI) begin
          nxt = S_EXEC_I;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          nxt = S_ADDR;
        end else if (opcode == OP_BEQ) begin
          nxt = S_BRANCH;
        end else begin
          nxt     = S_TRAP;
          cause_n = CAUSE_ILLEGAL;
        end
      end
      S_EXEC_R: nxt = S_WB_R;
      S_WB_R:   nxt = S_FETCH;
      S_EXEC_I: nxt = S_WB_I;
      S_WB_I:   nxt = S_FETCH;
      S_ADDR:   nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) begin
          nxt = S_WB_MEM;
        end else if (timeout_hit) begin
          nxt     = S_TRAP;
          cause_n = CAUSE_TIMEOUT;
        end
      end
      S_WB_MEM: nxt = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) begin
          nxt = S_FETCH;
        end else if (timeout_hit) begin
          nxt     = S_TRAP;
          cause_n = CAUSE_TIMEOUT;
        end
      end
      S_BRANCH: nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_IDLE;
    endcase
  end

  // State, registered controls, wait counter, trap flags and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_IDLE;
      ctrl_q   <= ctrl_for(S_IDLE, 6'b000000);
      wait_cnt <= '0;
      count_q  <= '0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      cur    <= nxt;
      ctrl_q <= ctrl_for(nxt, funct);
      // Counts consecutive not-ready cycles inside one wait state; any exit clears it.
      if (in_wait && !mem_ready && (nxt == cur)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (nxt == S_TRAP && cur != S_TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= cause_n;
      end
    end
  end

  assign mem_req     = ctrl_q.mem_req;
  assign mem_we      = ctrl_q.mem_we;
  assign iord        = ctrl_q.iord;
  assign pc_src      = ctrl_q.pc_src;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_op      = ctrl_q.alu_op;
  assign reg_we      = ctrl_q.reg_we;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign ir_we       = (cur == S_FETCH) && mem_ready;
  assign pc_we       = ((cur == S_FETCH) && mem_ready) || ((cur == S_BRANCH) && zero);
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign instr_count = count_q;
  assign state       = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a driver walks each instruction through the
// phases the ISA rules imply, pushing the expected per-cycle observation into
// a queue; a monitor on the falling edge pops and compares.
module tb_multicycle_control;

  localparam int TO = 4;
  localparam int CW = 2;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
    S_EXEC_R = 4'd3, S_WB_R = 4'd4, S_EXEC_I = 4'd5, S_WB_I = 4'd6,
    S_ADDR = 4'd7, S_MEM_RD = 4'd8, S_WB_MEM = 4'd9, S_MEM_WR = 4'd10,
    S_BRANCH = 4'd11, S_TRAP = 4'd12;

  typedef struct packed {
    logic [3:0]    st;
    logic          mem_req;
    logic          mem_we;
    logic          iord;
    logic          ir_we;
    logic          pc_we;
    logic [1:0]    pc_src;
    logic          a;
    logic [1:0]    b;
    logic [3:0]    op;
    logic          reg_we;
    logic          reg_dst;
    logic          mem_to_reg;
    logic          trap;
    logic [1:0]    cause;
    logic [CW-1:0] cnt;
  } obs_t;

  localparam int W = $bits(obs_t);

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   ins;
  logic          zero;
  logic          mem_ready;
  logic          mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0]    pc_src;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic [3:0]    alu_op;
  logic          reg_we, reg_dst, mem_to_reg, trap;
  logic [1:0]    trap_cause;
  logic [CW-1:0] instr_count;
  logic [3:0]    state;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            m_count;
  logic          m_trap;
  logic [1:0]    m_cause;

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .trap(trap),
    .trap_cause(trap_cause), .instr_count(instr_count), .state(state)
  );

  // Clock
  always #5 clk = ~clk;

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    obs_t e;
    obs_t g;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g.st = state; g.mem_req = mem_req; g.mem_we = mem_we; g.iord = iord;
      g.ir_we = ir_we; g.pc_we = pc_we; g.pc_src = pc_src; g.a = alu_src_a;
      g.b = alu_src_b; g.op = alu_op; g.reg_we = reg_we; g.reg_dst = reg_dst;
      g.mem_to_reg = mem_to_reg; g.trap = trap; g.cause = trap_cause;
      g.cnt = instr_count;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL trace t=%0t got st=%0d vec=%h exp st=%0d vec=%h",
                 $time, g.st, g, e.st, e);
      end
    end
  end

  // Watchdog
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ISA reference tables
  function automatic logic fn_legal(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h24 || fn == 6'h25 || fn == 6'h22 || fn == 6'h2a;
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      6'h22:   return 4'b0110;
      6'h2a:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Quiet observation for a state under the current architectural model.
  function automatic obs_t base(input logic [3:0] st);
    obs_t o;
    o       = '0;
    o.st    = st;
    o.op    = 4'b0010;
    o.trap  = m_trap;
    o.cause = m_cause;
    o.cnt   = CW'(m_count);
    return o;
  endfunction

  // One clock cycle: drive inputs, optionally push expectation, advance.
  task automatic cyc(input obs_t e, input logic push, input logic r,
                     input logic rdy, input logic z);
    rst = r; mem_ready = rdy; zero = z;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(base(S_TRAP), 1'b1, 1'b0, rb(), rb());
  endtask

  task automatic do_reset();
    cyc(base(S_IDLE), 1'b0, 1'b1, rb(), rb());
    m_count = 0; m_trap = 1'b0; m_cause = 2'b00;
    cyc(base(S_IDLE), 1'b1, 1'b1, rb(), rb());
    cyc(base(S_IDLE), 1'b1, 1'b0, rb(), rb());
  endtask

  // Memory phase: dly not-ready cycles then one ready cycle. The TO-th
  // consecutive not-ready cycle traps; rst_at asserts reset in that wait cycle.
  task automatic mem_phase(input logic [3:0] st, input int dly, input int rst_at,
                           output logic early);
    obs_t e;
    early = 1'b0;
    for (int i = 0; i < dly; i++) begin
      e = base(st);
      e.mem_req = 1'b1;
      if (st == S_FETCH) e.b = 2'b01; else e.iord = 1'b1;
      if (st == S_MEM_WR) e.mem_we = 1'b1;
      cyc(e, 1'b1, (i == rst_at), 1'b0, rb());
      if (i == rst_at) begin
        m_count = 0; m_trap = 1'b0; m_cause = 2'b00;
        cyc(base(S_IDLE), 1'b1, 1'b0, rb(), rb());
        early = 1'b1;
        return;
      end
      if (i == TO - 1) begin
        m_trap = 1'b1; m_cause = 2'b10;
        trap_cycles(3);
        early = 1'b1;
        return;
      end
    end
    e = base(st);
    e.mem_req = 1'b1;
    if (st == S_FETCH) begin
      e.b = 2'b01; e.ir_we = 1'b1; e.pc_we = 1'b1;
    end else begin
      e.iord = 1'b1;
    end
    if (st == S_MEM_WR) e.mem_we = 1'b1;
    cyc(e, 1'b1, 1'b0, 1'b1, rb());
  endtask

  // Walk one instruction starting in FETCH.
  task automatic run_instr(input logic [31:0] iv, input logic z, input int df,
                           input int dm, input int rst_at);
    obs_t e;
    logic early;
    logic [5:0] op;
    logic [5:0] fn;
    op = iv[31:26];
    fn = iv[5:0];
    ins = iv;
    mem_phase(S_FETCH, df, -1, early);
    if (early) return;
    e = base(S_DECODE); e.b = 2'b11;
    cyc(e, 1'b1, 1'b0, rb(), rb());
    if (op == 6'd0 && fn_legal(fn)) begin
      e = base(S_EXEC_R); e.a = 1'b1; e.op = alu_of(fn);
      cyc(e, 1'b1, 1'b0, rb(), rb());
      e = base(S_WB_R); e.reg_we = 1'b1; e.reg_dst = 1'b1;
      cyc(e, 1'b1, 1'b0, rb(), rb());
      m_count++;
    end else if (op == 6'd8) begin
      e = base(S_EXEC_I); e.a = 1'b1; e.b = 2'b10;
      cyc(e, 1'b1, 1'b0, rb(), rb());
      e = base(S_WB_I); e.reg_we = 1'b1;
      cyc(e, 1'b1, 1'b0, rb(), rb());
      m_count++;
    end else if (op == 6'd35 || op == 6'd43) begin
      e = base(S_ADDR); e.a = 1'b1; e.b = 2'b10;
      cyc(e, 1'b1, 1'b0, rb(), rb());
      mem_phase((op == 6'd35) ? S_MEM_RD : S_MEM_WR, dm, rst_at, early);
      if (early) return;
      if (op == 6'd35) begin
        e = base(S_WB_MEM); e.reg_we = 1'b1; e.mem_to_reg = 1'b1;
        cyc(e, 1'b1, 1'b0, rb(), rb());
      end
      m_count++;
    end else if (op == 6'd4) begin
      e = base(S_BRANCH); e.a = 1'b1; e.op = 4'b0110; e.pc_src = 2'b01; e.pc_we = z;
      cyc(e, 1'b1, 1'b0, rb(), z);
      m_count++;
    end else begin
      m_trap = 1'b1; m_cause = 2'b01;
      trap_cycles(10);
    end
  endtask

  // One not-ready FETCH cycle to observe the retire count; reset follows.
  task automatic count_check();
    obs_t e;
    e = base(S_FETCH); e.mem_req = 1'b1; e.b = 2'b01;
    cyc(e, 1'b1, 1'b0, 1'b0, rb());
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [5:0] op;
    logic [5:0] fn;
    logic [25:0] body;
    k    = $urandom_range(0, 6);
    body = 26'($urandom);
    case (k)
      0: begin
        case ($urandom_range(0, 4))
          0: fn = 6'h20; 1: fn = 6'h24; 2: fn = 6'h25; 3: fn = 6'h22;
          default: fn = 6'h2a;
        endcase
        return {6'd0, body[25:6], fn};
      end
      1: return {6'd8, body};
      2: return {6'd35, body};
      3: return {6'd43, body};
      4: return {6'd4, body};
      5: begin
        op = 6'($urandom_range(0, 63));
        while (op == 6'd0 || op == 6'd8 || op == 6'd35 || op == 6'd43 || op == 6'd4)
          op = 6'($urandom_range(0, 63));
        return {op, body};
      end
      default: begin
        fn = 6'($urandom_range(0, 63));
        while (fn_legal(fn)) fn = 6'($urandom_range(0, 63));
        return {6'd0, body[25:6], fn};
      end
    endcase
  endfunction

  // Stimulus
  initial begin
    rst = 1'b1; ins = '0; zero = 1'b0; mem_ready = 1'b0;
    m_count = 0; m_trap = 1'b0; m_cause = 2'b00;
    do_reset();

    // add $3,$1,$2 with immediate ready
    run_instr(32'h00221820, 1'b0, 0, 0, -1);
    count_check();
    do_reset();

    // lw with 3 wait cycles, then beq taken and not taken
    run_instr(32'h8C220004, 1'b0, 0, 3, -1);
    run_instr(32'h10220003, 1'b1, 0, 0, -1);
    run_instr(32'h10220003, 1'b0, 0, 0, -1);
    count_check();
    do_reset();

    // illegal opcode, then illegal funct
    run_instr(32'hFC000000, 1'b0, 0, 0, -1);
    do_reset();
    run_instr(32'h00221821, 1'b0, 0, 0, -1);
    do_reset();

    // fetch timeout; ready on the last allowed cycle; store timeout
    run_instr(32'h00221820, 1'b0, TO, 0, -1);
    do_reset();
    run_instr(32'h00221820, 1'b0, TO - 1, 0, -1);
    run_instr(32'hAC220008, 1'b0, 0, TO, -1);
    do_reset();

    // five addi wrap a 2-bit counter to 1
    for (int i = 0; i < 5; i++) run_instr(32'h20220005, 1'b0, 0, 0, -1);
    count_check();
    do_reset();

    // reset asserted during a store wait
    run_instr(32'hAC220008, 1'b0, 0, 3, 1);

    // randomized mix
    for (int i = 0; i < 80; i++) begin
      run_instr(rand_instr(), rb(), $urandom_range(0, TO), $urandom_range(0, TO), -1);
      if (m_trap) do_reset();
    end
    count_check();
    do_reset();

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
